neumaier_vec_loader: RTL



---
 rtl/neumaier_pkg.sv | 26 ++
 rtl/neumaier_result_fifo.sv | 59 +++++
 rtl/neumaier_vec_loader.sv | 120 ++++++++++++
 3 files changed

// File: rtl/neumaier_pkg.sv
// Shared widths, element/sum types and beat arithmetic for the Neumaier
// adder-tree feed and result path.
package neumaier_pkg;

    function automatic int unsigned bit_width(input int unsigned exp_w, input int unsigned mant_w);
        return 1 + exp_w + mant_w;
    endfunction

    function automatic int unsigned sum_width(input int unsigned elem_w, input int unsigned elems);
        return elem_w + $clog2(elems);
    endfunction

    function automatic int unsigned nbeats(input int unsigned elems, input int unsigned lanes);
        return elems / lanes;
    endfunction

    localparam int unsigned DEF_EXP_WIDTH  = 5;
    localparam int unsigned DEF_MANT_WIDTH = 2;
    localparam int unsigned DEF_ELEMS      = 32;
    localparam int unsigned DEF_BIT_WIDTH  = bit_width(DEF_EXP_WIDTH, DEF_MANT_WIDTH);
    localparam int unsigned DEF_SUM_WIDTH  = sum_width(DEF_BIT_WIDTH, DEF_ELEMS);

    typedef logic [DEF_BIT_WIDTH-1:0] elem_t;
    typedef logic [DEF_SUM_WIDTH-1:0] sum_t;

endpackage

// File: rtl/neumaier_result_fifo.sv
// First-word-fall-through FIFO with full/empty flags; head is visible on
// data_o whenever empty_o is low.
module neumaier_result_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count == CW'(DEPTH));
    assign empty_o = (count == '0);
    assign data_o  = mem[rd_ptr];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= wrap_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= wrap_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) (push_i && full_o) |-> pop_i);

endmodule

// File: rtl/neumaier_vec_loader.sv
// Gathers LANES-wide beats into a full vector, launches it into the adder
// tree, and queues the tree's sum once the fixed tree latency has elapsed.
module neumaier_vec_loader
    import neumaier_pkg::*;
#(
    parameter int unsigned EXP_WIDTH_I  = 5,
    parameter int unsigned MANT_WIDTH_I = 2,
    parameter int unsigned ELEMS_COUNT  = 32,
    parameter int unsigned LANES        = 4,
    parameter int unsigned TREE_LATENCY = 8,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned SUM_WIDTH_O  = sum_width(bit_width(EXP_WIDTH_I, MANT_WIDTH_I), ELEMS_COUNT),
    localparam int unsigned BIT_WIDTH_I = bit_width(EXP_WIDTH_I, MANT_WIDTH_I)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               s_valid_i,
    output logic                               s_ready_o,
    input  logic [LANES*BIT_WIDTH_I-1:0]       s_data_i,
    input  logic                               s_last_i,
    output logic [ELEMS_COUNT*BIT_WIDTH_I-1:0] vec_o,
    output logic                               vec_valid_o,
    input  logic [SUM_WIDTH_O-1:0]             sum_i,
    output logic                               m_valid_o,
    input  logic                               m_ready_i,
    output logic [SUM_WIDTH_O-1:0]             m_sum_o,
    output logic                               err_len_o
);

    localparam int unsigned NBEATS  = nbeats(ELEMS_COUNT, LANES);
    localparam int unsigned BEAT_W  = LANES * BIT_WIDTH_I;
    localparam int unsigned VEC_W   = ELEMS_COUNT * BIT_WIDTH_I;
    localparam int unsigned BCNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int unsigned CRED_W  = $clog2(MAX_INFLIGHT + 1);
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(NBEATS - 1);

    logic [BCNT_W-1:0]       beat_cnt;
    logic [VEC_W-1:0]        fill_q;
    logic [VEC_W-1:0]        fill_merged;
    logic [CRED_W-1:0]       credits;
    logic [CRED_W-1:0]       credits_nxt;
    logic [TREE_LATENCY-1:0] lat_pipe;
    logic                    accept;
    logic                    last_beat;
    logic                    complete;
    logic                    push;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;

    assign accept    = s_valid_i && s_ready_o;
    assign last_beat = (beat_cnt == LAST_BEAT);
    assign complete  = accept && (s_last_i || last_beat);
    assign push      = lat_pipe[TREE_LATENCY-1];
    assign m_valid_o = !fifo_empty;
    assign pop       = m_valid_o && m_ready_i;

    // Unwritten beats are already zero because the fill buffer clears on each
    // completion, so an early s_last_i needs no extra masking.
    always_comb begin
        fill_merged = fill_q;
        for (int unsigned b = 0; b < NBEATS; b++) begin
            if (beat_cnt == BCNT_W'(b)) fill_merged[b*BEAT_W +: BEAT_W] = s_data_i;
        end
    end

    always_comb begin
        credits_nxt = credits;
        case ({complete, pop})
            2'b10:   credits_nxt = credits - 1'b1;
            2'b01:   credits_nxt = credits + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt    <= '0;
            fill_q      <= '0;
            vec_o       <= '0;
            vec_valid_o <= 1'b0;
            credits     <= CRED_W'(MAX_INFLIGHT);
            s_ready_o   <= 1'b0;
            err_len_o   <= 1'b0;
            lat_pipe    <= '0;
        end else begin
            vec_valid_o <= complete;
            credits     <= credits_nxt;
            s_ready_o   <= (credits_nxt != '0);
            lat_pipe    <= (lat_pipe << 1) | TREE_LATENCY'(vec_valid_o);
            if (complete) begin
                vec_o    <= fill_merged;
                fill_q   <= '0;
                beat_cnt <= '0;
                // Framing is bad when s_last_i and the final beat position disagree.
                if (s_last_i != last_beat) err_len_o <= 1'b1;
            end else if (accept) begin
                fill_q   <= fill_merged;
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    neumaier_result_fifo #(
        .WIDTH (SUM_WIDTH_O),
        .DEPTH (MAX_INFLIGHT)
    ) u_result_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (sum_i),
        .pop_i   (pop),
        .data_o  (m_sum_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    a_full_means_no_credit: assert property (@(posedge clk_i) disable iff (!rst_ni) fifo_full |-> (credits == '0));

endmodule
